rv_decode_stage: RTL and testbench

Single-entry decode/operand stage directly upstream of the ALU. Accepts one RV32I instruction per handshake, reads two source registers from an internal 32x32 register file, builds the immediate, and presents a registered `alu_function`/`op_a`/`op_b` bundle to the ALU. The register file write port is driven by writeback and has a same-cycle write-to-read bypass.

---
 rtl/rv_decode_stage_if.sv | 29 ++
 rtl/rv_decode_stage.sv | 133 +++++++++++++
 tb/tb_rv_decode_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_decode_stage_if.sv
// Handshake and operand bundle between issue, writeback and the ALU for rv_decode_stage.
// The master side drives instructions and writeback; the slave side is the decode stage.
interface rv_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_insn;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      alu_function;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [4:0]      rd;
  logic            illegal;

  modport master (
    output in_valid, in_insn, wb_en, wb_rd, wb_data, out_ready,
    input  in_ready, out_valid, alu_function, op_a, op_b, rd, illegal
  );

  modport slave (
    input  in_valid, in_insn, wb_en, wb_rd, wb_data, out_ready,
    output in_ready, out_valid, alu_function, op_a, op_b, rd, illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// RV32I decode/operand stage: 32x32 register file with writeback bypass feeding a
// single-entry registered ALU bundle (EMPTY/FULL) under a valid/ready handshake.
module rv_decode_stage #(
  parameter int XLEN = 32
) (
  input logic              clock,
  input logic              reset,
  rv_decode_stage_if.slave bus
);
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic {EMPTY, FULL} state_e;

  state_e          state_q;
  logic [4:0]      fn_q, fn_d;
  logic [XLEN-1:0] opa_q, opa_d;
  logic [XLEN-1:0] opb_q, opb_d;
  logic [4:0]      rd_q, rd_d;
  logic            ill_q, ill_d;
  logic [XLEN-1:0] rf_q [32];

  logic [6:0]      opc, f7;
  logic [2:0]      f3;
  logic [4:0]      rs1, rs2, rd_f;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            f7_ok, is_shift, accept;

  assign opc  = bus.in_insn[6:0];
  assign rd_f = bus.in_insn[11:7];
  assign f3   = bus.in_insn[14:12];
  assign rs1  = bus.in_insn[19:15];
  assign rs2  = bus.in_insn[24:20];
  assign f7   = bus.in_insn[31:25];

  // The alternate funct7 is only meaningful for SUB and SRA/SRAI.
  assign f7_ok    = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
  assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

  assign bus.in_ready = (state_q == EMPTY) || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // A writeback landing in the accept cycle is forwarded; x0 never is.
  assign rs1_val = (rs1 == 5'd0) ? '0 :
                   (bus.wb_en && (bus.wb_rd == rs1)) ? bus.wb_data : rf_q[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 :
                   (bus.wb_en && (bus.wb_rd == rs2)) ? bus.wb_data : rf_q[rs2];

  function automatic logic [4:0] alu_fn(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  alu_fn = alt ? ALU_SUB : ALU_ADD;
      3'b001:  alu_fn = ALU_SLL;
      3'b010:  alu_fn = ALU_SLT;
      3'b011:  alu_fn = ALU_SLTU;
      3'b100:  alu_fn = ALU_XOR;
      3'b101:  alu_fn = alt ? ALU_SRA : ALU_SRL;
      3'b110:  alu_fn = ALU_OR;
      default: alu_fn = ALU_AND;
    endcase
  endfunction

  always_comb begin
    fn_d  = ALU_ADD;
    opa_d = '0;
    opb_d = '0;
    rd_d  = '0;
    ill_d = 1'b1;
    if ((opc == OPC_R) && f7_ok) begin
      ill_d = 1'b0;
      fn_d  = alu_fn(f3, f7[5]);
      opa_d = rs1_val;
      opb_d = rs2_val;
      rd_d  = rd_f;
    end else if ((opc == OPC_I) && is_shift && f7_ok) begin
      ill_d = 1'b0;
      fn_d  = alu_fn(f3, f7[5]);
      opa_d = rs1_val;
      opb_d = {{(XLEN-5){1'b0}}, rs2};
      rd_d  = rd_f;
    end else if ((opc == OPC_I) && !is_shift) begin
      ill_d = 1'b0;
      fn_d  = alu_fn(f3, 1'b0);
      opa_d = rs1_val;
      opb_d = {{(XLEN-12){bus.in_insn[31]}}, bus.in_insn[31:20]};
      rd_d  = rd_f;
    end
  end

  // Register file is not reset; a write during reset still lands.
  always_ff @(posedge clock) begin
    if (bus.wb_en && (bus.wb_rd != 5'd0)) rf_q[bus.wb_rd] <= bus.wb_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= EMPTY;
      fn_q    <= ALU_ADD;
      opa_q   <= '0;
      opb_q   <= '0;
      rd_q    <= '0;
      ill_q   <= 1'b0;
    end else if (accept) begin
      state_q <= FULL;
      fn_q    <= fn_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      rd_q    <= rd_d;
      ill_q   <= ill_d;
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_q <= EMPTY;
    end
  end

  assign bus.out_valid    = (state_q == FULL);
  assign bus.alu_function = fn_q;
  assign bus.op_a         = opa_q;
  assign bus.op_b         = opb_q;
  assign bus.rd           = rd_q;
  assign bus.illegal      = ill_q;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Scoreboard bench for rv_decode_stage: a table-driven RV32I reference model predicts
// each accepted bundle, and a monitor compares every presented bundle in order.
module tb_rv_decode_stage;
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLL  = 5'd2;
  localparam logic [4:0] ALU_SLT  = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_OR   = 5'd8;
  localparam logic [4:0] ALU_AND  = 5'd9;

  localparam logic [6:0] OR_ = 7'b0110011;
  localparam logic [6:0] OI_ = 7'b0010011;
  localparam logic [1:0] K_R = 2'd0, K_I = 2'd1, K_SH = 2'd2;
  localparam int NOPS = 19;

  typedef struct packed {
    logic [6:0] opc; logic [2:0] f3; logic [6:0] f7; logic [4:0] fn; logic [1:0] kind;
  } op_t;
  typedef struct packed {
    logic [4:0] fn; logic [31:0] a; logic [31:0] b; logic [4:0] rd; logic ill;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  rv_decode_stage_if #(.XLEN(32)) bus();
  rv_decode_stage #(.XLEN(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  int    n_tests = 0;
  int    n_fail  = 0;
  exp_t  exp_q[$];
  logic [31:0] ref_rf [32];
  op_t   ops [NOPS];

  // Architectural register state as seen by the model.
  always @(posedge clock) begin
    if (bus.wb_en === 1'b1 && bus.wb_rd != 5'd0) ref_rf[bus.wb_rd] = bus.wb_data;
  end

  function automatic op_t mk(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                             input logic [4:0] fn, input logic [1:0] kind);
    mk = '{opc: opc, f3: f3, f7: f7, fn: fn, kind: kind};
  endfunction

  function automatic exp_t mkexp(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic ill);
    mkexp = '{fn: fn, a: a, b: b, rd: rd, ill: ill};
  endfunction

  function automatic logic [31:0] reg_val(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_en && bus.wb_rd == r) return bus.wb_data;
    return ref_rf[r];
  endfunction

  // Match the word against the supported-instruction table; anything unmatched is illegal.
  function automatic exp_t model(input logic [31:0] insn);
    exp_t e;
    op_t  o;
    e = mkexp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1);
    for (int k = 0; k < NOPS; k++) begin
      o = ops[k];
      if (insn[6:0] == o.opc && insn[14:12] == o.f3 && (o.kind == K_I || insn[31:25] == o.f7)) begin
        e.ill = 1'b0;
        e.fn  = o.fn;
        e.rd  = insn[11:7];
        e.a   = reg_val(insn[19:15]);
        if (o.kind == K_R)      e.b = reg_val(insn[24:20]);
        else if (o.kind == K_I) e.b = {{20{insn[31]}}, insn[31:20]};
        else                    e.b = {27'd0, insn[24:20]};
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_insn();
    op_t o;
    logic [4:0] r1, r2, rdd;
    logic [11:0] imm;
    if ($urandom_range(0, 3) == 0) return $urandom;
    o   = ops[$urandom_range(0, NOPS-1)];
    r1  = 5'($urandom);
    r2  = 5'($urandom);
    rdd = 5'($urandom);
    imm = 12'($urandom);
    if (o.kind == K_I) return {imm, r1, o.f3, rdd, o.opc};
    return {o.f7, r2, r1, o.f3, rdd, o.opc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  // Monitor: every presented bundle must equal the head of the queue; popped on consume.
  exp_t mon_e, mon_a;
  always @(negedge clock) begin
    if (bus.out_valid === 1'b1) begin
      mon_a = {bus.alu_function, bus.op_a, bus.op_b, bus.rd, bus.illegal};
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bundle_extra: got fn=%0d a=%h b=%h rd=%0d ill=%0b, expected no bundle",
                 mon_a.fn, mon_a.a, mon_a.b, mon_a.rd, mon_a.ill);
      end else begin
        mon_e = exp_q[0];
        if (mon_a !== mon_e) begin
          n_fail++;
          $display("FAIL bundle: got fn=%0d a=%h b=%h rd=%0d ill=%0b, expected fn=%0d a=%h b=%h rd=%0d ill=%0b",
                   mon_a.fn, mon_a.a, mon_a.b, mon_a.rd, mon_a.ill,
                   mon_e.fn, mon_e.a, mon_e.b, mon_e.rd, mon_e.ill);
        end
        if (bus.out_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  // One clock of stimulus, starting and ending just after a rising edge.
  task automatic cycle_drive(input logic v, input logic [31:0] insn, input logic ordy,
                             input logic we, input logic [4:0] wr, input logic [31:0] wd,
                             input logic use_exp, input exp_t ex, output logic acc);
    bus.in_valid  = v;
    bus.in_insn   = insn;
    bus.out_ready = ordy;
    bus.wb_en     = we;
    bus.wb_rd     = wr;
    bus.wb_data   = wd;
    @(negedge clock);
    acc = v && (bus.in_ready === 1'b1);
    if (acc) exp_q.push_back(use_exp ? ex : model(insn));
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic ordy);
    logic acc;
    for (int i = 0; i < n; i++) cycle_drive(1'b0, 32'd0, ordy, 1'b0, 5'd0, 32'd0, 1'b0, '0, acc);
  endtask

  task automatic issue(input string name, input logic [31:0] insn, input logic ordy,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic use_exp, input exp_t ex);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle_drive(1'b1, insn, ordy, we, wr, wd, use_exp, ex, acc);
      n++;
    end while (!acc && n < 20);
    if (!acc) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_accept_timeout: got no accept in %0d cycles, expected accept", name, n);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_in_ready"},  {31'd0, bus.in_ready},  32'd1);
    check({tag, "_alu_fn"},    {27'd0, bus.alu_function}, {27'd0, ALU_ADD});
    check({tag, "_op_a"},      bus.op_a, 32'd0);
    check({tag, "_op_b"},      bus.op_b, 32'd0);
    check({tag, "_rd"},        {27'd0, bus.rd}, 32'd0);
    check({tag, "_illegal"},   {31'd0, bus.illegal}, 32'd0);
  endtask

  initial begin
    logic        acc, v, ordy, we;
    logic [31:0] pend, wd;
    logic [4:0]  wr;

    ops[0]  = mk(OR_, 3'b000, 7'h00, ALU_ADD,  K_R);
    ops[1]  = mk(OR_, 3'b000, 7'h20, ALU_SUB,  K_R);
    ops[2]  = mk(OR_, 3'b001, 7'h00, ALU_SLL,  K_R);
    ops[3]  = mk(OR_, 3'b010, 7'h00, ALU_SLT,  K_R);
    ops[4]  = mk(OR_, 3'b011, 7'h00, ALU_SLTU, K_R);
    ops[5]  = mk(OR_, 3'b100, 7'h00, ALU_XOR,  K_R);
    ops[6]  = mk(OR_, 3'b101, 7'h00, ALU_SRL,  K_R);
    ops[7]  = mk(OR_, 3'b101, 7'h20, ALU_SRA,  K_R);
    ops[8]  = mk(OR_, 3'b110, 7'h00, ALU_OR,   K_R);
    ops[9]  = mk(OR_, 3'b111, 7'h00, ALU_AND,  K_R);
    ops[10] = mk(OI_, 3'b000, 7'h00, ALU_ADD,  K_I);
    ops[11] = mk(OI_, 3'b010, 7'h00, ALU_SLT,  K_I);
    ops[12] = mk(OI_, 3'b011, 7'h00, ALU_SLTU, K_I);
    ops[13] = mk(OI_, 3'b100, 7'h00, ALU_XOR,  K_I);
    ops[14] = mk(OI_, 3'b110, 7'h00, ALU_OR,   K_I);
    ops[15] = mk(OI_, 3'b111, 7'h00, ALU_AND,  K_I);
    ops[16] = mk(OI_, 3'b001, 7'h00, ALU_SLL,  K_SH);
    ops[17] = mk(OI_, 3'b101, 7'h00, ALU_SRL,  K_SH);
    ops[18] = mk(OI_, 3'b101, 7'h20, ALU_SRA,  K_SH);

    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_insn = 32'd0; bus.out_ready = 1'b0;
    bus.wb_en = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check_reset_outputs("por");

    for (int i = 1; i < 32; i++) begin
      wd = (i == 1) ? 32'd5 : (i == 2) ? 32'd3 : $urandom;
      cycle_drive(1'b0, 32'd0, 1'b1, 1'b1, 5'(i), wd, 1'b0, '0, acc);
    end

    issue("sub",  {7'h20, 5'd2, 5'd1, 3'b000, 5'd3, OR_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_SUB, 32'd5, 32'd3, 5'd3, 1'b0));
    issue("addi", {12'hFFF, 5'd1, 3'b000, 5'd4, OI_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd4, 1'b0));
    issue("srai", {7'h20, 5'd4, 5'd1, 3'b101, 5'd5, OI_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_SRA, 32'd5, 32'd4, 5'd5, 1'b0));
    issue("bypass", {7'h00, 5'd0, 5'd7, 3'b000, 5'd6, OR_}, 1'b1, 1'b1, 5'd7, 32'hDEAD_BEEF,
          1'b1, mkexp(ALU_ADD, 32'hDEAD_BEEF, 32'd0, 5'd6, 1'b0));
    cycle_drive(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'h1234, 1'b0, '0, acc);
    issue("x0_read", {7'h00, 5'd0, 5'd0, 3'b000, 5'd8, OR_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'd0, 32'd0, 5'd8, 1'b0));
    issue("x0_nobypass", {7'h00, 5'd0, 5'd0, 3'b000, 5'd8, OR_}, 1'b1, 1'b1, 5'd0, 32'h1234,
          1'b1, mkexp(ALU_ADD, 32'd0, 32'd0, 5'd8, 1'b0));
    idle(2, 1'b1);

    // Backpressure: a held bundle, then three back-to-back accepts.
    issue("bp_first", {7'h00, 5'd2, 5'd1, 3'b100, 5'd10, OR_}, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      cycle_drive(1'b1, {7'h00, 5'd3, 5'd4, 3'b110, 5'd11, OR_}, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, '0, acc);
      check("bp_in_ready_low", {31'd0, acc}, 32'd0);
    end
    cycle_drive(1'b1, {7'h00, 5'd3, 5'd4, 3'b110, 5'd11, OR_}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, '0, acc);
    check("b2b_accept0", {31'd0, acc}, 32'd1);
    cycle_drive(1'b1, {12'h7FF, 5'd5, 3'b111, 5'd12, OI_}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, '0, acc);
    check("b2b_accept1", {31'd0, acc}, 32'd1);
    cycle_drive(1'b1, {7'h00, 5'd31, 5'd6, 3'b001, 5'd13, OI_}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, '0, acc);
    check("b2b_accept2", {31'd0, acc}, 32'd1);

    issue("ill_opc", 32'h0000_007F, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1));
    issue("ill_f7", {7'b0100001, 5'd2, 5'd1, 3'b000, 5'd3, OR_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1));
    issue("ill_slli_alt", {7'h20, 5'd3, 5'd1, 3'b001, 5'd3, OI_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'd0, 32'd0, 5'd0, 1'b1));
    idle(2, 1'b1);

    pend = rand_insn();
    for (int i = 0; i < 500; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      we   = 1'($urandom);
      wr   = 5'($urandom);
      wd   = $urandom;
      cycle_drive(v, pend, ordy, we, wr, wd, 1'b0, '0, acc);
      if (acc) pend = rand_insn();
    end
    idle(3, 1'b1);
    check("drain_queue_empty", exp_q.size(), 32'd0);

    // Reset while FULL and stalled: bundle discarded, writeback still lands.
    issue("pre_reset", {7'h00, 5'd2, 5'd1, 3'b000, 5'd14, OR_}, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, '0);
    reset = 1'b1;
    cycle_drive(1'b0, 32'd0, 1'b0, 1'b1, 5'd9, 32'hCAFE_0009, 1'b0, '0, acc);
    exp_q.delete();
    reset = 1'b0;
    bus.wb_en = 1'b0;
    check_reset_outputs("midrst");
    issue("post_reset", {7'h00, 5'd0, 5'd9, 3'b000, 5'd11, OR_}, 1'b1, 1'b0, 5'd0, 32'd0,
          1'b1, mkexp(ALU_ADD, 32'hCAFE_0009, 32'd0, 5'd11, 1'b0));
    idle(3, 1'b1);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by 1000000, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
